// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream writer for the CPU instruction memory.
// Frame: SYNC_BYTE, LEN, LEN data bytes, CSUM (8-bit sum of data bytes).
// Holds the CPU (cpu_hold) while a load is in progress and releases it only
// after a checksum-correct image has been written.
// Optional read-back verification pass: define PROG_LOADER_VERIFY_EN.
module prog_loader #(
  parameter int          ADDR_W      = 4,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 1200000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;              // holds LEN up to DEPTH
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
`ifdef PROG_LOADER_VERIFY_EN
    , S_VERIFY
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  idx_inc;
  logic [7:0]        acc_q, acc_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic              accept;
  logic              in_frame;

`ifdef PROG_LOADER_VERIFY_EN
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        vsum;
`else
  // Read data only matters for the verification pass.
  logic              unused_rdata;
  assign unused_rdata = ^mem_rdata;
`endif

  assign accept   = in_valid && in_ready_q;
  assign idx_inc  = idx_q + 1'b1;
  assign in_frame = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);

  // Next-state and next-output computation for the whole loader.
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    to_cnt_d    = '0;
    in_ready_d  = in_ready_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;
`ifdef PROG_LOADER_VERIFY_EN
    csum_d      = csum_q;
    vsum        = (idx_q != '0) ? acc_q + mem_rdata : acc_q;
`endif

    if (in_frame && !accept) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    case (state_q)
      // IDLE, DONE and ERR all wait for a sync byte; anything else is dropped.
      S_IDLE, S_DONE, S_ERR: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d    = S_LEN;
          cpu_hold_d = 1'b1;
          load_err_d = 1'b0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_LEN: begin
        if (accept) begin
          if (in_data == 8'd0 || int'(in_data) > DEPTH) begin
            state_d    = S_ERR;
            load_err_d = 1'b1;
          end else begin
            len_d   = CNT_W'(in_data);
            idx_d   = '0;
            acc_d   = '0;
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q[ADDR_W-1:0];
          mem_wdata_d = in_data;
          acc_d       = acc_q + in_data;
          idx_d       = idx_inc;
          if (idx_inc == len_q) begin
            state_d = S_CSUM;
          end
        end
      end

      S_CSUM: begin
        if (accept) begin
          if (in_data == acc_q) begin
`ifdef PROG_LOADER_VERIFY_EN
            // Re-read the image: idx counts read cycles, acc reused as sum.
            state_d    = S_VERIFY;
            in_ready_d = 1'b0;
            csum_d     = in_data;
            idx_d      = '0;
            acc_d      = '0;
            mem_addr_d = '0;
`else
            state_d     = S_DONE;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
`endif
          end else begin
            // Bytes already written stay in memory; the CPU stays held.
            state_d    = S_ERR;
            load_err_d = 1'b1;
          end
        end
      end

`ifdef PROG_LOADER_VERIFY_EN
      // Address issued at idx=c returns data sampled at idx=c+1.
      S_VERIFY: begin
        acc_d = vsum;
        if (idx_q == len_q) begin
          in_ready_d = 1'b1;
          if (vsum == csum_q) begin
            state_d     = S_DONE;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            state_d    = S_ERR;
            load_err_d = 1'b1;
          end
        end else begin
          idx_d = idx_inc;
          if (idx_inc < len_q) begin
            mem_addr_d = idx_inc[ADDR_W-1:0];
          end
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Inter-byte timeout aborts the frame; no byte was accepted this cycle.
    if (in_frame && !accept && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
      state_d    = S_ERR;
      load_err_d = 1'b1;
      to_cnt_d   = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      to_cnt_q    <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
      csum_q      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      to_cnt_q    <= to_cnt_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
`ifdef PROG_LOADER_VERIFY_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. Expected memory writes are queued as
// frames are driven and popped by a monitor whenever mem_we is seen.
module tb_prog_loader;

  localparam int ADDR_W = 4;
  localparam int TO_CYC = 20;

  logic              clk;
  logic              rst_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t  exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   done_cnt     = 0;
  logic corrupt_en   = 1'b0;
  logic [7:0] mem [16];

  prog_loader #(
    .ADDR_W     (ADDR_W),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: synchronous write, 1-cycle read latency,
  // optional corruption of address 1 on read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr] ^ ((corrupt_en && mem_addr == 4'd1) ? 8'h01 : 8'h00);
  end

  // Write monitor / scoreboard and load_done pulse counter.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_done) done_cnt++;
      if (mem_we) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write addr=%0h data=%02h", mem_addr, mem_wdata);
          tests_failed++;
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data) begin
            $display("FAIL write got addr=%0h data=%02h expected addr=%0h data=%02h",
                     mem_addr, mem_wdata, e.addr, e.data);
            tests_failed++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one byte and wait (bounded) for the handshake. Starts and ends
  // just after a rising edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests_run++;
    if (n >= 100) begin
      $display("FAIL handshake_timeout byte=%02h in_ready=%b expected 1", b, in_ready);
      tests_failed++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_queue_empty(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s pending_writes=%0d expected 0", name, exp_q.size());
      tests_failed++;
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    tests_run++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err} !==
        {1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_values got rdy=%b we=%b addr=%0h wd=%02h hold=%b done=%b err=%b",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err);
      tests_failed++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    int d0 = done_cnt;
    send(8'hA5);
    tests_run++;
    if (cpu_hold !== 1'b1) begin
      $display("FAIL good_hold_after_sync got %b expected 1", cpu_hold); tests_failed++;
    end
    send(8'h03);
    exp_q.push_back('{4'd0, 8'h01}); send(8'h01);
    exp_q.push_back('{4'd1, 8'h02}); send(8'h02);
    exp_q.push_back('{4'd2, 8'h03}); send(8'h03);
    send(8'h06);
    idle(25);
    tests_run++;
    if (done_cnt - d0 !== 1) begin
      $display("FAIL good_done_pulses got %0d expected 1", done_cnt - d0); tests_failed++;
    end
    tests_run++;
    if (cpu_hold !== 1'b0 || load_err !== 1'b0) begin
      $display("FAIL good_final got hold=%b err=%b expected 0 0", cpu_hold, load_err); tests_failed++;
    end
    check_queue_empty("good_writes");
  endtask

  task automatic test_bad_csum();
    int d0 = done_cnt;
    send(8'hA5); send(8'h02);
    exp_q.push_back('{4'd0, 8'h10}); send(8'h10);
    exp_q.push_back('{4'd1, 8'h20}); send(8'h20);
    send(8'h31);
    idle(25);
    tests_run++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1 || done_cnt != d0) begin
      $display("FAIL badcsum got err=%b hold=%b done=%0d expected 1 1 0",
               load_err, cpu_hold, done_cnt - d0); tests_failed++;
    end
    send(8'hA5);
    tests_run++;
    if (load_err !== 1'b0 || cpu_hold !== 1'b1) begin
      $display("FAIL badcsum_resync got err=%b hold=%b expected 0 1", load_err, cpu_hold); tests_failed++;
    end
    send(8'h01);
    exp_q.push_back('{4'd0, 8'h07}); send(8'h07);
    send(8'h07);
    idle(25);
    tests_run++;
    if (done_cnt - d0 !== 1 || load_err !== 1'b0 || cpu_hold !== 1'b0) begin
      $display("FAIL badcsum_recover got done=%0d err=%b hold=%b expected 1 0 0",
               done_cnt - d0, load_err, cpu_hold); tests_failed++;
    end
    check_queue_empty("badcsum_writes");
  endtask

  task automatic test_full_frame();
    int d0 = done_cnt;
    send(8'h00); send(8'hFF);
    tests_run++;
    if (cpu_hold !== 1'b0) begin
      $display("FAIL garbage_hold got %b expected 0", cpu_hold); tests_failed++;
    end
    send(8'hA5); send(8'h10);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{4'(i), 8'hFF});
      send(8'hFF);
    end
    send(8'hF0);
    idle(25);
    tests_run++;
    if (done_cnt - d0 !== 1 || load_err !== 1'b0 || cpu_hold !== 1'b0) begin
      $display("FAIL full_frame got done=%0d err=%b hold=%b expected 1 0 0",
               done_cnt - d0, load_err, cpu_hold); tests_failed++;
    end
    check_queue_empty("full_writes");
  endtask

  task automatic test_bad_len();
    send(8'hA5); send(8'h00);
    idle(2);
    tests_run++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin
      $display("FAIL len0 got err=%b hold=%b expected 1 1", load_err, cpu_hold); tests_failed++;
    end
    send(8'hA5); send(8'h11);
    idle(2);
    tests_run++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin
      $display("FAIL len17 got err=%b hold=%b expected 1 1", load_err, cpu_hold); tests_failed++;
    end
    // A data byte after the error must not be written.
    send(8'h33);
    idle(2);
    check_queue_empty("badlen_writes");
  endtask

  task automatic test_timeout();
    send(8'hA5); send(8'h02);
    exp_q.push_back('{4'd0, 8'h01}); send(8'h01);
    idle(15);
    tests_run++;
    if (load_err !== 1'b0) begin
      $display("FAIL timeout_early got err=%b expected 0", load_err); tests_failed++;
    end
    idle(7);
    tests_run++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin
      $display("FAIL timeout got err=%b hold=%b expected 1 1", load_err, cpu_hold); tests_failed++;
    end
    check_queue_empty("timeout_writes");
  endtask

  task automatic test_async_reset();
    int d0;
    send(8'hA5); send(8'h02);
    exp_q.push_back('{4'd0, 8'h05}); send(8'h05);
    idle(1);
    #1;
    rst_n = 1'b0;
    #2;
    tests_run++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err} !==
        {1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL async_reset got rdy=%b we=%b addr=%0h wd=%02h hold=%b done=%b err=%b",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err);
      tests_failed++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    d0 = done_cnt;
    // Back in IDLE: a stray byte is ignored, then a full frame loads.
    send(8'h05);
    send(8'hA5); send(8'h01);
    exp_q.push_back('{4'd0, 8'h07}); send(8'h07);
    send(8'h07);
    idle(25);
    tests_run++;
    if (done_cnt - d0 !== 1 || cpu_hold !== 1'b0) begin
      $display("FAIL post_reset_load got done=%0d hold=%b expected 1 0", done_cnt - d0, cpu_hold);
      tests_failed++;
    end
    check_queue_empty("reset_writes");
  endtask

`ifdef PROG_LOADER_VERIFY_EN
  task automatic test_verify();
    int d0 = done_cnt;
    corrupt_en = 1'b1;
    send(8'hA5); send(8'h02);
    exp_q.push_back('{4'd0, 8'h05}); send(8'h05);
    exp_q.push_back('{4'd1, 8'h05}); send(8'h05);
    send(8'h0A);
    tests_run++;
    if (in_ready !== 1'b0) begin
      $display("FAIL verify_ready got %b expected 0", in_ready); tests_failed++;
    end
    idle(10);
    tests_run++;
    if (load_err !== 1'b1 || done_cnt != d0 || cpu_hold !== 1'b1) begin
      $display("FAIL verify_corrupt got err=%b done=%0d hold=%b expected 1 0 1",
               load_err, done_cnt - d0, cpu_hold); tests_failed++;
    end
    corrupt_en = 1'b0;
    check_queue_empty("verify_writes");
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_full_frame();
    test_bad_len();
    test_timeout();
    test_async_reset();
`ifdef PROG_LOADER_VERIFY_EN
    test_verify();
`endif
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
